// File: rtl/hit_judge.sv
// hit_judge: judges whack-a-mole button presses against the live mole slots.
// Raw active-low hole buttons are synchronised, optionally debounced, and
// edge-detected. The lowest-numbered new press in a cycle is compared against
// the five mole nibbles. A matching press pulses kill_list for every matching
// slot and scores a hit; otherwise it counts as a miss. Escapes reported by the
// mole generator clear the combo.
// Build option: define KEY_DEBOUNCE_EN to enable the per-key DB_CYCLES debounce
// filter. When it is undefined, the stable level is the synchronised level and
// DB_CYCLES has no effect.
module hit_judge #(
    parameter logic [19:0] DB_CYCLES = 20'd500000,
    parameter logic [13:0] SCORE_MAX = 14'd9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_en,
    input  logic        clear,
    input  logic [8:0]  keys_n,
    input  logic [19:0] moles,
    input  logic        survival,
    output logic [4:0]  kill_list,
    output logic [13:0] score,
    output logic [7:0]  miss_cnt,
    output logic [7:0]  escape_cnt,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo
);

    localparam int NKEYS  = 9;
    localparam int NSLOTS = 5;

    // ------------------------------------------------------------------
    // Saturating increment helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [13:0] sat_inc_score(input logic [13:0] v);
        return (v >= SCORE_MAX) ? SCORE_MAX : v + 14'd1;
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser, start-up settle counter and per-key arming
    // ------------------------------------------------------------------
    logic [NKEYS-1:0] sync1_q, sync2_q;
    logic [1:0]       settle_q, settle_d;
    logic             settled;
    logic [NKEYS-1:0] arm_q, arm_d;
    logic [NKEYS-1:0] stable_q, stable_d;

    // The synchroniser holds zeros for two edges after reset. A key is only
    // armed once it has been seen released through a filled synchroniser, so
    // a key held across reset cannot fire until it is released and re-pressed.
    assign settled  = (settle_q == 2'd2);
    assign settle_d = settled ? settle_q : settle_q + 2'd1;
    assign arm_d    = arm_q | (~sync2_q & {NKEYS{settled}});

    // Two-flop synchroniser (inverting to active-high), settle counter, arm flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            settle_q <= 2'd0;
            arm_q    <= '0;
        end else begin
            sync1_q  <= ~keys_n;
            sync2_q  <= sync1_q;
            settle_q <= settle_d;
            arm_q    <= arm_d;
        end
    end

    // ------------------------------------------------------------------
    // Stable key level
    // ------------------------------------------------------------------
`ifdef KEY_DEBOUNCE_EN
    logic [NKEYS-1:0][19:0] db_cnt_q, db_cnt_d;

    // Count consecutive disagreeing cycles per key. The stable level flips on
    // the DB_CYCLES-th one; any agreeing cycle restarts the count. A
    // DB_CYCLES of 0 behaves like 1.
    always_comb begin
        db_cnt_d = '0;
        stable_d = stable_q;
        for (int k = 0; k < NKEYS; k++) begin
            if (sync2_q[k] != stable_q[k]) begin
                if (({1'b0, db_cnt_q[k]} + 21'd1) >= {1'b0, DB_CYCLES}) begin
                    stable_d[k] = sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 20'd1;
                end
            end
        end
    end

    // Debounce counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
        end
    end
`else
    // Without the filter the synchronised level is taken as stable directly.
    assign stable_d = sync2_q;

    // DB_CYCLES is kept on the interface so both builds share one port and
    // parameter list; this build has no counters to size with it.
    if (DB_CYCLES == 20'd0) begin : g_db_unused
    end
`endif

    // Stable key levels (released after reset)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable_d;
        end
    end

    // ------------------------------------------------------------------
    // Press detection and priority select
    // ------------------------------------------------------------------
    logic [NKEYS-1:0]  press;
    logic [3:0]        key_idx;
    logic              press_any;
    logic [NSLOTS-1:0] match;
    logic              judge, hit, miss;

    // A press is the 0->1 edge of the stable level, seen in the same cycle the
    // stable level rises.
    assign press = stable_d & ~stable_q & arm_q;

    // Lowest-numbered pressed key wins; other same-cycle presses are dropped.
    always_comb begin
        key_idx   = 4'd0;
        press_any = 1'b0;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (press[k]) begin
                key_idx   = 4'(k);
                press_any = 1'b1;
            end
        end
    end

    // Slot match against the judged key; the empty code 4'b1111 never matches.
    always_comb begin
        match = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            match[i] = (moles[4*i +: 4] == key_idx) && (moles[4*i +: 4] != 4'hF);
        end
    end

    assign judge = press_any & game_en;
    assign hit   = judge & (|match);
    assign miss  = judge & ~(|match);

    // ------------------------------------------------------------------
    // Score, combo and statistics
    // ------------------------------------------------------------------
    logic [4:0]  kill_q, kill_d;
    logic [13:0] score_q, score_d;
    logic [7:0]  miss_q, miss_d;
    logic [7:0]  escape_q, escape_d;
    logic [7:0]  combo_q, combo_d;
    logic [7:0]  max_q, max_d;
    logic [7:0]  combo_base;
    logic        escaped;

    assign escaped = survival & game_en;

    // Next-state for counters. An escape clears the combo before a same-cycle
    // hit adds to it; clear overrides everything.
    always_comb begin
        combo_base = escaped ? 8'd0 : combo_q;
        kill_d     = hit ? match : 5'd0;
        score_d    = hit ? sat_inc_score(score_q) : score_q;
        miss_d     = miss ? sat_inc8(miss_q) : miss_q;
        escape_d   = escaped ? sat_inc8(escape_q) : escape_q;
        if (hit) begin
            combo_d = sat_inc8(combo_base);
        end else if (miss) begin
            combo_d = 8'd0;
        end else begin
            combo_d = combo_base;
        end
        max_d = (combo_d > max_q) ? combo_d : max_q;
        if (clear) begin
            kill_d   = 5'd0;
            score_d  = 14'd0;
            miss_d   = 8'd0;
            escape_d = 8'd0;
            combo_d  = 8'd0;
            max_d    = 8'd0;
        end
    end

    // Counter and kill-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_q   <= '0;
            score_q  <= '0;
            miss_q   <= '0;
            escape_q <= '0;
            combo_q  <= '0;
            max_q    <= '0;
        end else begin
            kill_q   <= kill_d;
            score_q  <= score_d;
            miss_q   <= miss_d;
            escape_q <= escape_d;
            combo_q  <= combo_d;
            max_q    <= max_d;
        end
    end

    assign kill_list  = kill_q;
    assign score      = score_q;
    assign miss_cnt   = miss_q;
    assign escape_cnt = escape_q;
    assign combo      = combo_q;
    assign max_combo  = max_q;

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed-vector bench for hit_judge. Inputs change and outputs
// are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_hit_judge;

    localparam logic [19:0] DB = 20'd4;
`ifdef KEY_DEBOUNCE_EN
    localparam int H = 4;      // cycles a key must be held for one press
`else
    localparam int H = 1;
`endif
    // Edges from driving a key low to the kill_list / counter update.
    localparam int LAT = H + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        game_en;
    logic        clear;
    logic [8:0]  keys_n;
    logic [19:0] moles;
    logic        survival;
    logic [4:0]  kill_list;
    logic [13:0] score;
    logic [7:0]  miss_cnt, escape_cnt, combo, max_combo;

    int vectors = 0;
    int miscompares = 0;

    hit_judge #(.DB_CYCLES(DB), .SCORE_MAX(14'd9999)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .game_en    (game_en),
        .clear      (clear),
        .keys_n     (keys_n),
        .moles      (moles),
        .survival   (survival),
        .kill_list  (kill_list),
        .score      (score),
        .miss_cnt   (miss_cnt),
        .escape_cnt (escape_cnt),
        .combo      (combo),
        .max_combo  (max_combo)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    // Drive the keys in mask low and stop in the judging cycle.
    task automatic press_begin(input logic [8:0] mask);
        keys_n = ~mask;
        tick(LAT - 1);
    endtask

    task automatic release_all();
        keys_n = 9'h1FF;
        tick(LAT + 2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; game_en = 1'b1; clear = 1'b0; keys_n = 9'h1FF;
        moles = 20'hFFFFF; survival = 1'b0;
        tick(2);
        vectors++; if (kill_list !== 5'd0) begin miscompares++; $display("FAIL reset_kill got %b want %b", kill_list, 5'd0); end
        vectors++; if (score !== 14'd0) begin miscompares++; $display("FAIL reset_score got %0d want 0", score); end
        vectors++; if (miss_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_miss got %0d want 0", miss_cnt); end
        vectors++; if (escape_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_escape got %0d want 0", escape_cnt); end
        vectors++; if (combo !== 8'd0) begin miscompares++; $display("FAIL reset_combo got %0d want 0", combo); end
        vectors++; if (max_combo !== 8'd0) begin miscompares++; $display("FAIL reset_max got %0d want 0", max_combo); end
        rst_n = 1'b1;
        tick(4);
    endtask

    // Key 3 low for 3 cycles: rejected by the debounce filter; without the
    // filter it is an ordinary hit on slot 1.
    task automatic test_glitch();
        logic [13:0] exp_score;
`ifdef KEY_DEBOUNCE_EN
        exp_score = 14'd0;
`else
        exp_score = 14'd1;
`endif
        moles = 20'hFFF3F;
        keys_n[3] = 1'b0;
        tick(3);
        keys_n[3] = 1'b1;
        tick(LAT + 4);
        vectors++; if (score !== exp_score) begin miscompares++; $display("FAIL glitch_score got %0d want %0d", score, exp_score); end
        vectors++; if (miss_cnt !== 8'd0) begin miscompares++; $display("FAIL glitch_miss got %0d want 0", miss_cnt); end
        vectors++; if (kill_list !== 5'd0) begin miscompares++; $display("FAIL glitch_kill got %b want 00000", kill_list); end
        do_clear();
        vectors++; if (score !== 14'd0) begin miscompares++; $display("FAIL clear_score got %0d want 0", score); end
        vectors++; if (combo !== 8'd0) begin miscompares++; $display("FAIL clear_combo got %0d want 0", combo); end
        vectors++; if (max_combo !== 8'd0) begin miscompares++; $display("FAIL clear_max got %0d want 0", max_combo); end
    endtask

    task automatic test_hit();
        moles = 20'hFFF3F;
        press_begin(9'h008);
        vectors++; if (kill_list !== 5'd0) begin miscompares++; $display("FAIL hit_kill_early got %b want 00000", kill_list); end
        tick(1);
        vectors++; if (kill_list !== 5'b00010) begin miscompares++; $display("FAIL hit_kill got %b want 00010", kill_list); end
        vectors++; if (score !== 14'd1) begin miscompares++; $display("FAIL hit_score got %0d want 1", score); end
        vectors++; if (combo !== 8'd1) begin miscompares++; $display("FAIL hit_combo got %0d want 1", combo); end
        vectors++; if (max_combo !== 8'd1) begin miscompares++; $display("FAIL hit_max got %0d want 1", max_combo); end
        tick(1);
        vectors++; if (kill_list !== 5'd0) begin miscompares++; $display("FAIL hit_kill_one_cycle got %b want 00000", kill_list); end
        tick(LAT + 2);
        vectors++; if (score !== 14'd1) begin miscompares++; $display("FAIL held_no_repeat got %0d want 1", score); end
        release_all();
        moles = 20'h3FF3F;
        press_begin(9'h008);
        tick(1);
        vectors++; if (kill_list !== 5'b10010) begin miscompares++; $display("FAIL hit2_kill got %b want 10010", kill_list); end
        vectors++; if (combo !== 8'd2) begin miscompares++; $display("FAIL hit2_combo got %0d want 2", combo); end
        release_all();
    endtask

    task automatic test_miss();
        moles = 20'hFFFFF;
        press_begin(9'h001);
        tick(1);
        vectors++; if (kill_list !== 5'd0) begin miscompares++; $display("FAIL miss_kill got %b want 00000", kill_list); end
        vectors++; if (miss_cnt !== 8'd1) begin miscompares++; $display("FAIL miss_cnt got %0d want 1", miss_cnt); end
        vectors++; if (combo !== 8'd0) begin miscompares++; $display("FAIL miss_combo got %0d want 0", combo); end
        vectors++; if (max_combo !== 8'd2) begin miscompares++; $display("FAIL miss_max got %0d want 2", max_combo); end
        vectors++; if (score !== 14'd2) begin miscompares++; $display("FAIL miss_score got %0d want 2", score); end
        release_all();
    endtask

    task automatic test_multi();
        do_clear();
        moles = 20'hFFFF5;
        press_begin(9'h024);
        tick(1);
        vectors++; if (kill_list !== 5'd0) begin miscompares++; $display("FAIL multi_kill got %b want 00000", kill_list); end
        vectors++; if (miss_cnt !== 8'd1) begin miscompares++; $display("FAIL multi_miss got %0d want 1", miss_cnt); end
        vectors++; if (score !== 14'd0) begin miscompares++; $display("FAIL multi_score got %0d want 0", score); end
        release_all();
        vectors++; if (miss_cnt !== 8'd1) begin miscompares++; $display("FAIL multi_dropped got %0d want 1", miss_cnt); end
    endtask

    task automatic test_survival_hit();
        do_clear();
        moles = 20'hFFF3F;
        for (int i = 0; i < 3; i++) begin
            press_begin(9'h008);
            tick(1);
            release_all();
        end
        vectors++; if (combo !== 8'd3) begin miscompares++; $display("FAIL pre_combo got %0d want 3", combo); end
        press_begin(9'h008);
        survival = 1'b1;
        tick(1);
        survival = 1'b0;
        vectors++; if (combo !== 8'd1) begin miscompares++; $display("FAIL surv_hit_combo got %0d want 1", combo); end
        vectors++; if (escape_cnt !== 8'd1) begin miscompares++; $display("FAIL surv_hit_escape got %0d want 1", escape_cnt); end
        vectors++; if (score !== 14'd4) begin miscompares++; $display("FAIL surv_hit_score got %0d want 4", score); end
        vectors++; if (max_combo !== 8'd3) begin miscompares++; $display("FAIL surv_hit_max got %0d want 3", max_combo); end
        vectors++; if (kill_list !== 5'b00010) begin miscompares++; $display("FAIL surv_hit_kill got %b want 00010", kill_list); end
        release_all();
        survival = 1'b1;
        tick(1);
        survival = 1'b0;
        vectors++; if (escape_cnt !== 8'd2) begin miscompares++; $display("FAIL surv_escape got %0d want 2", escape_cnt); end
        vectors++; if (combo !== 8'd0) begin miscompares++; $display("FAIL surv_combo got %0d want 0", combo); end
    endtask

    task automatic test_game_en();
        game_en = 1'b0;
        press_begin(9'h008);
        survival = 1'b1;
        tick(1);
        survival = 1'b0;
        vectors++; if (kill_list !== 5'd0) begin miscompares++; $display("FAIL dis_kill got %b want 00000", kill_list); end
        vectors++; if (score !== 14'd4) begin miscompares++; $display("FAIL dis_score got %0d want 4", score); end
        vectors++; if (escape_cnt !== 8'd2) begin miscompares++; $display("FAIL dis_escape got %0d want 2", escape_cnt); end
        game_en = 1'b1;
        tick(LAT + 2);
        vectors++; if (score !== 14'd4) begin miscompares++; $display("FAIL en_held_score got %0d want 4", score); end
        vectors++; if (miss_cnt !== 8'd0) begin miscompares++; $display("FAIL en_held_miss got %0d want 0", miss_cnt); end
        release_all();
    endtask

    task automatic test_clear_override();
        press_begin(9'h008);
        clear = 1'b1;
        survival = 1'b1;
        tick(1);
        clear = 1'b0;
        survival = 1'b0;
        vectors++; if (kill_list !== 5'd0) begin miscompares++; $display("FAIL clr_kill got %b want 00000", kill_list); end
        vectors++; if (score !== 14'd0) begin miscompares++; $display("FAIL clr_score got %0d want 0", score); end
        vectors++; if (escape_cnt !== 8'd0) begin miscompares++; $display("FAIL clr_escape got %0d want 0", escape_cnt); end
        vectors++; if (max_combo !== 8'd0) begin miscompares++; $display("FAIL clr_max got %0d want 0", max_combo); end
        release_all();
    endtask

    task automatic test_reset_held();
        moles = 20'hFFF3F;
        keys_n = 9'h1F7;
        tick(2);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(LAT + 6);
        vectors++; if (score !== 14'd0) begin miscompares++; $display("FAIL rst_held_score got %0d want 0", score); end
        vectors++; if (kill_list !== 5'd0) begin miscompares++; $display("FAIL rst_held_kill got %b want 00000", kill_list); end
        release_all();
        press_begin(9'h008);
        tick(1);
        vectors++; if (kill_list !== 5'b00010) begin miscompares++; $display("FAIL repress_kill got %b want 00010", kill_list); end
        vectors++; if (score !== 14'd1) begin miscompares++; $display("FAIL repress_score got %0d want 1", score); end
        release_all();
    endtask

    task automatic test_saturation();
        do_clear();
        moles = 20'hFFF3F;
        for (int i = 0; i < 9999; i++) begin
            keys_n[3] = 1'b0;
            tick(H);
            keys_n[3] = 1'b1;
            tick(H);
        end
        tick(LAT + 2);
        vectors++; if (score !== 14'd9999) begin miscompares++; $display("FAIL preload_score got %0d want 9999", score); end
        vectors++; if (combo !== 8'd255) begin miscompares++; $display("FAIL preload_combo got %0d want 255", combo); end
        vectors++; if (max_combo !== 8'd255) begin miscompares++; $display("FAIL preload_max got %0d want 255", max_combo); end
        press_begin(9'h008);
        tick(1);
        vectors++; if (kill_list !== 5'b00010) begin miscompares++; $display("FAIL sat_kill got %b want 00010", kill_list); end
        vectors++; if (score !== 14'd9999) begin miscompares++; $display("FAIL sat_score got %0d want 9999", score); end
        vectors++; if (combo !== 8'd255) begin miscompares++; $display("FAIL sat_combo got %0d want 255", combo); end
        release_all();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_hit();
        test_miss();
        test_multi();
        test_survival_hit();
        test_game_en();
        test_clear_override();
        test_reset_held();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 SHALL provide parameter DB_CYCLES, default 20'd500000, key stable cycles for debounce acceptance.
REQ-002 SHALL provide parameter SCORE_MAX, default 14'd9999, score saturation ceiling.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port game_en  input  1  high = presses judged; low = presses ignored, counters hold.
REQ-006 SHALL have port clear  input  1  synchronous clear of all counters.
REQ-007 SHALL have port keys_n  input  9  raw hole buttons, active-low, bit k = hole k.
REQ-008 SHALL have port moles  input  20  five 4-bit mole locations, slot i = bits [4i+3:4i], 4'b1111 = empty slot.
REQ-009 SHALL have port survival  input  1  one-cycle pulse: a mole escaped.
REQ-010 SHALL have port kill_list  output  5  one-cycle per-slot kill pulses to the mole generator.
REQ-011 SHALL have ports score  output  14, miss_cnt  output  8, escape_cnt  output  8, combo  output  8, max_combo  output  8.

Function
REQ-012 SHALL pass keys_n through a 2-flop synchronizer, inverting to active-high.
REQ-013 SHALL keep per-key stable state; stable flips only after synchronized value differs from it for DB_CYCLES consecutive cycles; any agreement restarts that key's counter at 0.
REQ-014 SHALL generate press pulse for key k on stable 0->1 edge only; release and held keys generate nothing.
REQ-015 SHALL, when multiple presses occur in one cycle, judge only lowest-numbered key; others dropped, not counted.
REQ-016 SHALL compare judged key index k (0..8) with all five moles nibbles in press cycle T.
REQ-017 SHALL assert kill_list[i] for exactly cycle T+1 for every slot i whose nibble equals k; empty slots (4'b1111) never match.
REQ-018 SHALL treat a press with at least one match as hit: score +1 (saturate at SCORE_MAX), combo +1 (saturate 255), both visible in T+1.
REQ-019 SHALL treat a press with no match as miss: miss_cnt +1 (saturate 255), combo -> 0, kill_list stays 0.
REQ-020 SHALL update max_combo to combo whenever new combo exceeds it, same edge as combo.
REQ-021 SHALL, on survival pulse, increment escape_cnt (saturate 255) and clear combo.
REQ-022 SHALL, on survival and hit in same cycle, apply survival first: combo becomes 1, escape_cnt and score both increment.
REQ-023 SHALL, with game_en low, suppress judging (kill_list 0) and freeze counters; debounce keeps running so a key held across enable rising does not fire.
REQ-024 SHALL, on clear, zero all counters and kill_list next edge; clear overrides same-cycle hit/miss/survival.

Reset
REQ-025 SHALL on rst_n low asynchronously zero kill_list, score, miss_cnt, escape_cnt, combo, max_combo, synchronizers, debounce counters, stable states (released).
REQ-026 SHALL, on reset mid-debounce, discard partial counts; no press generated by reset release with key already held until it is released and re-pressed.

Configuration
REQ-027 SHALL use macro KEY_DEBOUNCE_EN: defined -> REQ-013 debounce active; undefined -> stable state equals synchronized key each cycle, DB_CYCLES ignored, debounce counters absent.

Verification
REQ-028 SHALL cover: DB_CYCLES=4, moles=20'hFFF3F, key 3 held 4 cycles -> kill_list=5'b00010 one cycle, score=1, combo=1.
REQ-029 SHALL cover: key 3 glitch low 3 cycles, DB_CYCLES=4 -> no press, kill_list 0, all counters 0.
REQ-030 SHALL cover: moles=20'hFFFFF, key 0 pressed -> kill_list 0, miss_cnt=1, combo=0, max_combo unchanged.
REQ-031 SHALL cover: keys 2 and 5 pressed same cycle, moles slot0=5 -> key 2 judged only, miss_cnt=1, kill_list 0.
REQ-032 SHALL cover: combo=3, hit and survival same cycle -> combo=1, escape_cnt=1, score=4, max_combo=3.
REQ-033 SHALL cover: score preloaded by 9999 hits, one more hit -> score stays 9999, kill_list still pulses.
